// File: rtl/key_cond_pkg.sv
// Shared defaults for the key conditioner slice.
package key_cond_pkg;
    localparam int unsigned DefWidth      = 2;
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefDbCycles   = 4;
endpackage

// File: rtl/key_cond_if.sv
// Raw-in / conditioned-out bundle between switch pins, key_cond and the moore controller.
interface key_cond_if
    import key_cond_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);
    logic [WIDTH-1:0] RAW;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;
    logic             CHG;

    modport master (output RAW, input X, input RISE, input FALL, input CHG);
    modport slave  (input RAW, output X, output RISE, output FALL, output CHG);
endinterface

// File: rtl/key_cond_ch.sv
// One conditioner channel: synchroniser chain, debounce counter, level register, edge strobes.
module key_cond_ch
    import key_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned DB_CYCLES   = DefDbCycles
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic x,
    output logic rise,
    output logic fall,
    output logic toggle
);
    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   x_q, rise_q, fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Counter only advances while the synchronised sample disagrees with the stable level.
    always_comb begin
        cnt_d  = '0;
        toggle = 1'b0;
        if (s != x_q) begin
            if (cnt_q == CntLast) begin
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
            cnt_q  <= '0;
            x_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q  <= cnt_d;
            if (toggle) begin
                x_q <= s;
            end
            rise_q <= toggle & s;
            fall_q <= toggle & ~s;
        end
    end

    assign x    = x_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/key_cond.sv
// Input conditioner for the moore X input: WIDTH independent channels plus a shared change flag.
module key_cond
    import key_cond_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned DB_CYCLES   = DefDbCycles
) (
    input logic       CLK,
    input logic       RST_N,
    key_cond_if.slave bus
);
    logic [WIDTH-1:0] x_vec, rise_vec, fall_vec, toggle_vec;
    logic             chg_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_cond_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_ch (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (bus.RAW[i]),
            .x     (x_vec[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i]),
            .toggle(toggle_vec[i])
        );
    end

    // Registered from the channels' next-edge toggles so it lines up with the strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= |toggle_vec;
        end
    end

    assign bus.X    = x_vec;
    assign bus.RISE = rise_vec;
    assign bus.FALL = fall_vec;
    assign bus.CHG  = chg_q;
endmodule
